// File: rtl/fetch_if.sv
// Fetch-stage bus: PC out to instruction memory, returned word in, hazard/redirect controls, IF/ID register contents.
interface fetch_if #(
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [31:0]              instr;
  logic                     stall;
  logic                     redirect_valid;
  logic [ADDRESS_WIDTH-1:0] redirect_target;
  logic                     if_id_valid;
  logic [31:0]              if_id_instr;
  logic [ADDRESS_WIDTH-1:0] if_id_pc;
  logic [ADDRESS_WIDTH-1:0] if_id_pc_plus4;
  logic                     if_id_pred_taken;

  modport master (
    output pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_pred_taken,
    input  instr, stall, redirect_valid, redirect_target
  );

  modport slave (
    input  pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_pred_taken,
    output instr, stall, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Optional static backward-taken/forward-not-taken prediction is enabled by defining FETCH_BTFN_PREDICT_EN.
module fetch_stage #(
  parameter int unsigned      ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0]      NOP_INSTR     = 32'h00000013
) (
  input  logic      clk,
  input  logic      rst,
  fetch_if.master   bus
);

  localparam int unsigned AW = ADDRESS_WIDTH;

  logic [AW-1:0] r_pc;
  logic          r_if_id_valid;
  logic [31:0]   r_if_id_instr;
  logic [AW-1:0] r_if_id_pc;
  logic [AW-1:0] r_if_id_pc_plus4;
  logic          r_if_id_pred_taken;

  logic [AW-1:0] w_pc_plus4;
  logic [AW-1:0] w_next_pc;
  logic          w_pred_taken;
  logic [AW-1:0] w_pred_target;

  assign w_pc_plus4 = r_pc + AW'(4);

`ifdef FETCH_BTFN_PREDICT_EN
  logic [31:0]   w_imm_b;
  logic [31:0]   w_imm_j;
  logic          w_is_back_br;
  logic          w_is_jal;
  logic [AW-1:0] w_target_sum;

  assign w_imm_b = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign w_imm_j = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
  assign w_is_back_br = (bus.instr[6:0] == 7'b1100011) && bus.instr[31];
  assign w_is_jal     = (bus.instr[6:0] == 7'b1101111);

  always_comb begin
    w_target_sum = r_pc + AW'($signed(w_imm_b));
    if (w_is_jal) w_target_sum = r_pc + AW'($signed(w_imm_j));
  end

  // Prediction is suppressed whenever the hazard unit or execute is steering the PC.
  assign w_pred_taken  = (w_is_back_br || w_is_jal) && !bus.stall && !bus.redirect_valid;
  assign w_pred_target = {w_target_sum[AW-1:2], 2'b00};
`else
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = w_pc_plus4;
`endif

  // Next-PC select: redirect > stall > predicted target > sequential.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (bus.redirect_valid) begin
      w_next_pc = {bus.redirect_target[AW-1:2], 2'b00};
    end else if (bus.stall) begin
      w_next_pc = r_pc;
    end else if (w_pred_taken) begin
      w_next_pc = w_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // IF/ID register: flush on reset or redirect, hold on stall, otherwise capture the fetched word.
  always_ff @(posedge clk) begin
    if (rst || bus.redirect_valid) begin
      r_if_id_valid      <= 1'b0;
      r_if_id_instr      <= NOP_INSTR;
      r_if_id_pc         <= '0;
      r_if_id_pc_plus4   <= '0;
      r_if_id_pred_taken <= 1'b0;
    end else if (!bus.stall) begin
      r_if_id_valid      <= 1'b1;
      r_if_id_instr      <= bus.instr;
      r_if_id_pc         <= r_pc;
      r_if_id_pc_plus4   <= w_pc_plus4;
      r_if_id_pred_taken <= w_pred_taken;
    end
  end

  assign bus.pc               = r_pc;
  assign bus.if_id_valid      = r_if_id_valid;
  assign bus.if_id_instr      = r_if_id_instr;
  assign bus.if_id_pc         = r_if_id_pc;
  assign bus.if_id_pc_plus4   = r_if_id_pc_plus4;
  assign bus.if_id_pred_taken = r_if_id_pred_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-cycle vectors push hand-computed post-edge state; a monitor pops and compares.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] RV  = 32'hBFC00000;
`ifdef FETCH_BTFN_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] ipc;
    logic        pred;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_idx  = 0;

  fetch_if #(.ADDRESS_WIDTH(32)) bus ();

  fetch_stage #(
    .ADDRESS_WIDTH(32),
    .RESET_VECTOR (32'hBFC00000),
    .NOP_INSTR    (32'h00000013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Instruction memory: beq x0,x0,-4 at BFC00020, jal x0,+16 at 0x4, otherwise addi-type words tagged by address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC00020: mem_word = 32'hFE000EE3;
      32'h00000004: mem_word = 32'h0100006F;
      default:      mem_word = {a[24:0], 7'b0010011};
    endcase
  endfunction

  assign bus.instr = mem_word(bus.pc);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs and push the state expected after the following edge.
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rt,
                      input logic [31:0] epc, input logic ev, input logic [31:0] eipc, input logic ep);
    exp_t e;
    @(negedge clk);
    rst                 = r;
    bus.stall           = s;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    e.idx   = vec_idx;
    e.pc    = epc;
    e.valid = ev;
    e.ipc   = eipc;
    e.pred  = ep;
    q.push_back(e);
    vec_idx++;
  endtask

  // Monitor: compare every field one step after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",        e.idx, bus.pc,                     e.pc);
        chk("valid",     e.idx, 32'(bus.if_id_valid),       32'(e.valid));
        chk("if_id_pc",  e.idx, bus.if_id_pc,               e.ipc);
        chk("instr",     e.idx, bus.if_id_instr,            e.valid ? mem_word(e.ipc) : NOP);
        chk("pc_plus4",  e.idx, bus.if_id_pc_plus4,         e.valid ? e.ipc + 32'd4 : 32'd0);
        chk("pred",      e.idx, 32'(bus.if_id_pred_taken),  32'(e.pred));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    // reset held two cycles, then sequential fetch
    step(1, 0, 0, 0, RV,          0, 0,           0);
    step(1, 0, 0, 0, RV,          0, 0,           0);
    step(0, 0, 0, 0, RV + 4,      1, RV,          0);
    step(0, 0, 0, 0, RV + 8,      1, RV + 4,      0);
    // stall three cycles at pc=BFC00008
    step(0, 1, 0, 0, RV + 8,      1, RV + 4,      0);
    step(0, 1, 0, 0, RV + 8,      1, RV + 4,      0);
    step(0, 1, 0, 0, RV + 8,      1, RV + 4,      0);
    step(0, 0, 0, 0, RV + 12,     1, RV + 8,      0);
    step(0, 0, 0, 0, RV + 16,     1, RV + 12,     0);
    // redirect with misaligned target
    step(0, 0, 1, 32'hBFC00103, 32'hBFC00100, 0, 0, 0);
    step(0, 0, 0, 0, 32'hBFC00104, 1, 32'hBFC00100, 0);
    step(0, 0, 0, 0, 32'hBFC00108, 1, 32'hBFC00104, 0);
    // redirect during stall
    step(0, 1, 1, 32'hBFC00040, 32'hBFC00040, 0, 0, 0);
    step(0, 0, 0, 0, 32'hBFC00044, 1, 32'hBFC00040, 0);
    // wrap at top of address space
    step(0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 0);
    step(0, 0, 0, 0, 32'h00000000, 1, 32'hFFFFFFFC, 0);
    step(0, 0, 0, 0, 32'h00000004, 1, 32'h00000000, 0);
    // redirect while a JAL sits in fetch: redirect wins
    step(0, 0, 1, 32'hBFC00020, 32'hBFC00020, 0, 0, 0);
    // backward beq at BFC00020
    step(0, 0, 0, 0, PRED ? 32'hBFC0001C : 32'hBFC00024, 1, 32'hBFC00020, PRED);
    step(0, 0, 0, 0, PRED ? 32'hBFC00020 : 32'hBFC00028, 1, PRED ? 32'hBFC0001C : 32'hBFC00024, 0);
    // stall while the branch is in fetch suppresses prediction
    step(0, 1, 0, 0, PRED ? 32'hBFC00020 : 32'hBFC00028, 1, PRED ? 32'hBFC0001C : 32'hBFC00024, 0);
    // reset mid-stream overrides redirect and stall
    step(1, 1, 1, 32'h00001000, RV, 0, 0, 0);
    step(0, 0, 0, 0, RV + 4,      1, RV,          0);
    // JAL at 0x4
    step(0, 0, 1, 32'h00000006, 32'h00000004, 0, 0, 0);
    step(0, 0, 0, 0, PRED ? 32'h00000014 : 32'h00000008, 1, 32'h00000004, PRED);
    step(0, 0, 0, 0, PRED ? 32'h00000018 : 32'h0000000C, 1, PRED ? 32'h00000014 : 32'h00000008, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Holds the program counter, drives it to the instruction memory, selects the next PC (sequential, predicted, or redirected from execute), and registers the returned word into the IF/ID pipeline register with stall and flush control. It sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- ADDRESS_WIDTH, 32, width of PC and all address ports.
- NOP_INSTR, 32'h00000013, instruction word placed in IF/ID on reset and flush (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc  output  ADDRESS_WIDTH  current fetch address, to instruction memory.
- instr  input  32  word returned combinationally by instruction memory for pc.
- stall  input  1  hazard unit: hold PC and IF/ID.
- redirect_valid  input  1  execute: resolved control flow differs from fetch path.
- redirect_target  input  ADDRESS_WIDTH  corrected PC from execute.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_instr  output  32  fetched instruction.
- if_id_pc  output  ADDRESS_WIDTH  address of if_id_instr.
- if_id_pc_plus4  output  ADDRESS_WIDTH  if_id_pc + 4.
- if_id_pred_taken  output  1  fetch redirected after this instruction.

## Operation
- pc is a register; pc output is that register directly.
- Next-PC priority, highest first: rst → RESET_VECTOR; redirect_valid → {redirect_target[31:2], 2'b00}; stall → hold; prediction taken → predicted target; otherwise pc + 4.
- pc + 4 is modulo 2^32: 32'hFFFFFFFC wraps to 32'h00000000.
- IF/ID update each edge, same priority: rst or redirect_valid → valid=0, instr=NOP_INSTR, pc=0, pc_plus4=0, pred_taken=0; stall → hold all fields; else load valid=1, instr, pc, pc+4, pred_taken.
- Redirect during stall: redirect wins; PC moves, IF/ID flushed, stall ignored that cycle.
- Redirect and predicted-taken in same cycle: redirect wins; prediction discarded.
- Prediction unit (see Configuration) inspects instr combinationally; never acts while stall or redirect_valid is high.
- Branch target arithmetic: pc + sign-extended immediate, modulo 2^32; bits [1:0] of result always 00.
- No instruction validity check; illegal opcodes pass to decode unchanged.

## Timing
- Reset values: pc=RESET_VECTOR, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, if_id_pred_taken=0.
- First edge after rst deasserts: IF/ID captures instruction at RESET_VECTOR with valid=1.
- Fetch-to-decode latency: 1 cycle (instr sampled at edge ending the cycle pc shows its address).
- Redirect penalty: 1 bubble; the instruction in fetch during redirect cycle is discarded, target appears in IF/ID one edge after it is fetched.
- Predicted-taken penalty: 0 bubbles; target fetched on the cycle after the branch.
- stall held N cycles → pc and IF/ID unchanged for N edges; release resumes with no lost or duplicated instruction.
- rst asserted mid-stream overrides everything on that edge.

## Configuration
- FETCH_BTFN_PREDICT_EN defined: static prediction. instr[6:0]=7'b1100011 (B-type) with instr[31]=1 (backward) → predicted taken, target pc + B-imm; instr[6:0]=7'b1101111 (JAL) → always taken, target pc + J-imm. if_id_pred_taken=1 for these. Forward branches, JALR predicted not-taken.
- Undefined: no prediction logic; next PC is pc+4 unless redirected/stalled; if_id_pred_taken tied 0.

## Test plan
- Reset: hold rst 2 cycles, release → pc=32'hBFC00000, if_id_valid=0; next edge if_id_pc=32'hBFC00000, valid=1, pc=32'hBFC00004.
- Stall: sequential fetch at 32'hBFC00008, stall=1 for 3 cycles → pc and IF/ID frozen 3 edges; release → IF/ID gets 0xBFC00008 word then 0xBFC0000C, no gaps.
- Redirect: redirect_valid=1, target=32'hBFC00103 at pc=32'hBFC00010 → next pc=32'hBFC00100, IF/ID valid=0 one cycle, then if_id_pc=32'hBFC00100.
- Redirect+stall same cycle: stall=1, redirect_valid=1, target=32'hBFC00040 → pc=32'hBFC00040, IF/ID flushed.
- Wrap: force redirect to 32'hFFFFFFFC → following pc=32'h00000000, if_id_pc_plus4=32'h00000000.
- With FETCH_BTFN_PREDICT_EN: pc=32'hBFC00020 fetches 32'hFE000EE3 (beq x0,x0,-4) → next pc=32'hBFC0001C, if_id_pred_taken=1; without macro next pc=32'hBFC00024, pred_taken=0.
